// File: rtl/vga_scanhalver.sv
// vga_scanhalver
//
// Converts 31 kHz VGA-rate RGB333 video into a 15 kHz stream for CRT TVs and
// SCART. Every second input line is stored in a two-bank line buffer. Each
// stored line is replayed once at half speed through an internal clock enable.
// The whole design runs from the single VGA pixel clock.
//
// Configuration macro: SCANHALVER_CSYNC_EN
//   defined     : hsync carries composite sync (hs & vsync), vsync tied high.
//   not defined : hsync and vsync are separate syncs.
//
// Parameters:
//   HSYNC_TICKS  output hsync pulse width, in half-rate read ticks
//   MIN_LINE     shortest accepted input line in clk cycles (multiple of 128, <= 896)
//
// Ports:
//   clk              VGA pixel clock, rising edge
//   rst              synchronous active-high reset
//   ri, gi, bi       input colour, 3 bits each
//   hsync_n, vsync_n input syncs, active low
//   ro, go, bo       output colour, registered
//   hsync            output horizontal (or composite) sync, active low, registered
//   vsync            output vertical sync, active low, registered

module vga_scanhalver #(
    parameter int unsigned HSYNC_TICKS = 56,
    parameter int unsigned MIN_LINE    = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ri,
    input  logic [2:0] gi,
    input  logic [2:0] bi,
    input  logic       hsync_n,
    input  logic       vsync_n,
    output logic [2:0] ro,
    output logic [2:0] go,
    output logic [2:0] bo,
    output logic       hsync,
    output logic       vsync
);

    localparam logic [2:0] MinBlk  = 3'(MIN_LINE / 128);
    localparam logic [9:0] HsTicks = 10'(HSYNC_TICKS);

    // Input register stage
    logic [8:0] rgb_q;
    logic       hs_q;
    logic       hs_prev_q;
    logic       vs_q;

    // Write side
    logic [9:0] waddr_q;
    logic [9:0] linelen_q;
    logic       odd_q;
    logic       wbank_q;
    logic       swap_q;
    logic       line_end;

    // Read side
    logic [9:0] raddr_q;
    logic       ce_q;
    logic [8:0] rdata_q;
    logic       hs_int;
    logic       hs_int_q;

    logic [8:0] mem [0:2047];

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q     <= '0;
            hs_q      <= 1'b1;
            hs_prev_q <= 1'b1;
            vs_q      <= 1'b1;
        end else begin
            rgb_q     <= {ri, gi, bi};
            hs_q      <= hsync_n;
            hs_prev_q <= hs_q;
            vs_q      <= vsync_n;
        end
    end

    // Falling hsync edges that arrive before MIN_LINE pixels are treated as glitches.
    assign line_end = hs_prev_q & ~hs_q & (waddr_q[9:7] >= MinBlk);

    always_ff @(posedge clk) begin
        if (rst) begin
            waddr_q   <= '0;
            linelen_q <= 10'd1023;
            odd_q     <= 1'b0;
            wbank_q   <= 1'b0;
            swap_q    <= 1'b0;
        end else begin
            swap_q <= 1'b0;
            if (line_end) begin
                waddr_q <= '0;
                odd_q   <= ~odd_q;
                if (!odd_q) begin
                    linelen_q <= waddr_q;
                    wbank_q   <= ~wbank_q;
                    swap_q    <= 1'b1;
                end
            end else begin
                // Natural 10-bit wrap keeps over-long lines inside their own bank.
                waddr_q <= waddr_q + 10'd1;
            end
        end
    end

    // Half-rate read: each address is held for two clk cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            raddr_q <= '0;
            ce_q    <= 1'b0;
        end else if (swap_q) begin
            raddr_q <= '0;
            ce_q    <= 1'b0;
        end else begin
            ce_q <= ~ce_q;
            if (ce_q) begin
                raddr_q <= (raddr_q == linelen_q) ? 10'd0 : raddr_q + 10'd1;
            end
        end
    end

    // Line buffer: only even lines are written; read bank is the opposite bank.
    always_ff @(posedge clk) begin
        if (!rst && !odd_q) begin
            mem[{wbank_q, waddr_q}] <= rgb_q;
        end
        rdata_q <= mem[{~wbank_q, raddr_q}];
    end

    assign hs_int = (raddr_q >= HsTicks);

    // Delay hs_int by the RAM read latency so it stays aligned with its pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_int_q <= 1'b1;
        end else begin
            hs_int_q <= hs_int;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ro    <= '0;
            go    <= '0;
            bo    <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            if (hs_int_q) begin
                {ro, go, bo} <= rdata_q;
            end else begin
                {ro, go, bo} <= '0;
            end
`ifdef SCANHALVER_CSYNC_EN
            hsync <= hs_int_q & vs_q;
            vsync <= 1'b1;
`else
            hsync <= hs_int_q;
            vsync <= vs_q;
`endif
        end
    end

endmodule

// File: tb/tb_vga_scanhalver.sv
// Self-checking bench for vga_scanhalver. A line-level reference model tracks
// which input lines are accepted, which are stored and when each stored line
// starts replaying; expected outputs are queued and compared by a monitor.

module tb_vga_scanhalver;

    localparam int HsTicks = 56;
    localparam int MinLine = 128;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] ri, gi, bi;
    logic       hsync_n, vsync_n;
    logic [2:0] ro, go, bo;
    logic       hsync, vsync;

    always #5 clk = ~clk;

    vga_scanhalver #(
        .HSYNC_TICKS(HsTicks),
        .MIN_LINE   (MinLine)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ri     (ri),
        .gi     (gi),
        .bi     (bi),
        .hsync_n(hsync_n),
        .vsync_n(vsync_n),
        .ro     (ro),
        .go     (go),
        .bo     (bo),
        .hsync  (hsync),
        .vsync  (vsync)
    );

    typedef struct {
        int         k;
        bit         chk_col;
        bit         chk_hs;
        logic [8:0] col;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int         k = 0;
    int         start_e = 0;
    bit         even_line = 1'b1;
    bit         partial = 1'b1;
    bit         prev_hs = 1'b1;
    bit         prev_vs = 1'b1;
    logic [8:0] cur_pix [1024];
    logic [8:0] pend_pix[1024];
    logic [8:0] act_pix [1024];
    int         pend_len, pend_e, act_len, act_e;
    bit         pend_set = 1'b0, pend_ok = 1'b0, act_set = 1'b0, act_ok = 1'b0;
    int         line_idx = 0;

    // Drives one clock's worth of pins and queues the output expected after that edge.
    task automatic step(input bit r, input logic [8:0] col, input bit h, input bit v);
        exp_t e;
        int   wa;
        int   j;
        int   idx;
        bit   h_exp;
        @(negedge clk);
        rst     = r;
        {ri, gi, bi} = col;
        hsync_n = h;
        vsync_n = v;
        k++;
        e.k = k; e.chk_col = 1'b0; e.chk_hs = 1'b0; e.col = '0; e.hs = 1'b1; e.vs = 1'b1;
        if (r) begin
            start_e = k; even_line = 1'b1; partial = 1'b1;
            prev_hs = 1'b1; prev_vs = 1'b1;
            pend_set = 1'b0; act_set = 1'b0;
            e.chk_col = 1'b1; e.chk_hs = 1'b1;
        end else begin
            if (pend_set && pend_e + 3 <= k) begin
                act_pix = pend_pix; act_len = pend_len; act_e = pend_e; act_ok = pend_ok;
                act_set = 1'b1; pend_set = 1'b0;
            end
`ifdef SCANHALVER_CSYNC_EN
            e.vs = 1'b1;
`else
            e.vs = prev_vs;
`endif
            if (act_set && act_ok) begin
                j     = k - act_e - 3;
                idx   = (j / 2) % (act_len + 1);
                h_exp = (idx >= HsTicks);
`ifdef SCANHALVER_CSYNC_EN
                e.hs = h_exp & prev_vs;
`else
                e.hs = h_exp;
`endif
                e.col    = h_exp ? act_pix[idx] : 9'd0;
                e.chk_hs = 1'b1;
                // The cycle two edges after a new line is committed reads the new bank
                // at the old replay index; that pixel belongs to no defined line.
                e.chk_col = !(pend_set && k == pend_e + 2);
            end
            prev_vs = v;
            wa = (k - start_e) % 1024;
            if (even_line) cur_pix[wa] = col;
            if (prev_hs && !h && wa >= MinLine) begin
                if (even_line) begin
                    pend_pix = cur_pix; pend_len = wa; pend_e = k + 1;
                    pend_ok = !partial; pend_set = 1'b1;
                end
                even_line = !even_line;
                partial   = 1'b0;
                start_e   = k + 1;
            end
            prev_hs = h;
        end
        exp_q.push_back(e);
    endtask

    // One input line: hsync low at the start, optional 1-clk glitch, optional reset burst.
    task automatic line(input int period, input int hsw, input bit idx_col, input int glitch_pos,
                        input bit vlow, input int rst_pos);
        logic [8:0] col;
        logic [2:0] li;
        bit         h;
        bit         r;
        for (int pos = 0; pos < period; pos++) begin
            h = !(pos < hsw);
            if (pos == glitch_pos) h = 1'b0;
            r = (rst_pos >= 0) && (pos >= rst_pos) && (pos < rst_pos + 3);
            li = 3'(line_idx);
            col = idx_col ? {li, li, li} : 9'($urandom);
            step(r, col, h, !vlow);
        end
        line_idx++;
    endtask

    task automatic cmp(input string name, input int kk, input logic [8:0] got,
                       input logic [8:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, kk, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk_col) cmp("colour", e.k, {ro, go, bo}, e.col);
                if (e.chk_hs) cmp("hsync", e.k, {8'd0, hsync}, {8'd0, e.hs});
                cmp("vsync", e.k, {8'd0, vsync}, {8'd0, e.vs});
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; ri = '0; gi = '0; bi = '0; hsync_n = 1'b1; vsync_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 9'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 12; i++) line(800, 96, 1'b1, -1, 1'b0, -1);
        for (int i = 0; i < 6; i++) line(800, 20, 1'b0, 40, 1'b0, -1);
        for (int i = 0; i < 8; i++) line(1100, 96, 1'b0, -1, 1'b0, -1);
        for (int i = 0; i < 10; i++) line(640, 96, 1'b0, -1, (i == 4) || (i == 5), -1);
        line(800, 96, 1'b0, -1, 1'b0, 300);
        for (int i = 0; i < 8; i++) line(800, 96, 1'b0, -1, 1'b0, -1);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
